// File: rtl/tag_lookup_pkg.sv
// Shared types and helpers for the tag lookup stage: entry layout and
// small one-hot / population helpers over a way vector.
package tag_lookup_pkg;

  localparam int DEF_SETS      = 2048;
  localparam int DEF_WAYS      = 4;
  localparam int DEF_TAG_WIDTH = 20;

  // One tag array entry; valid sits in the MSB so the packed form matches
  // the {valid, tag} layout the array stores.
  typedef struct packed {
    logic                     valid;
    logic [DEF_TAG_WIDTH-1:0] tag;
  } tag_entry_t;

  typedef logic [DEF_WAYS-1:0] way_vec_t;

  // Isolate the lowest set bit; returns zero for a zero input.
  function automatic way_vec_t onehot_lowest(input way_vec_t v);
    return v & (~v + way_vec_t'(1));
  endfunction

  // True when more than one bit is set: clearing the lowest set bit
  // leaves something behind.
  function automatic logic popcount_gt1(input way_vec_t v);
    return |(v & (v - way_vec_t'(1)));
  endfunction

endpackage

// File: rtl/tag_compare.sv
// Combinational compare of all ways of one set against a request tag.
// Produces the raw hit vector, the priority hit way, a multihit flag and
// the lowest invalid way as a replacement candidate.
module tag_compare
  import tag_lookup_pkg::*;
(
  input  tag_entry_t                 entries [DEF_WAYS],
  input  logic [DEF_TAG_WIDTH-1:0]   tag,
  output logic [DEF_WAYS-1:0]        hit_vec,
  output logic [DEF_WAYS-1:0]        hit_way,
  output logic                       multihit,
  output logic [DEF_WAYS-1:0]        inv_victim,
  output logic                       any_invalid
);

  logic [DEF_WAYS-1:0] inv_vec;

  // Per-way match and invalid detection, then priority reduction.
  // NOTE: every output of a combinational block gets a default before any
  // conditional logic so no path leaves a value unassigned (no latches).
  always_comb begin
    hit_vec = '0;
    inv_vec = '0;
    for (int i = 0; i < DEF_WAYS; i++) begin
      hit_vec[i] = entries[i].valid & (entries[i].tag == tag);
      inv_vec[i] = ~entries[i].valid;
    end
    hit_way     = onehot_lowest(hit_vec);
    multihit    = popcount_gt1(hit_vec);
    inv_victim  = onehot_lowest(inv_vec);
    any_invalid = |inv_vec;
  end

endmodule

// File: rtl/tag_lookup.sv
// Tag lookup stage around a synchronous-read tag array.
// S0: request handshake drives the array read. S1: array data returns, is
// patched by concurrent updates, compared. S2: registered response with
// valid/ready. Victim falls back to a round-robin pointer when every way is
// valid; the pointer is applied at S2 so back-to-back misses see each
// other's advance.
module tag_lookup
  import tag_lookup_pkg::*;
#(
  parameter int SETS        = DEF_SETS,
  parameter int WAYS        = DEF_WAYS,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int SET_WIDTH   = $clog2(SETS),
  parameter int ENTRY_WIDTH = TAG_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SET_WIDTH-1:0]   req_set,
  input  logic [TAG_WIDTH-1:0]   req_tag,

  input  logic                   upd_valid,
  input  logic [SET_WIDTH-1:0]   upd_set,
  input  logic [WAYS-1:0]        upd_way,
  input  logic [ENTRY_WIDTH-1:0] upd_entry,

  output logic                   arr_ren,
  output logic [SET_WIDTH-1:0]   arr_raddr,
  input  logic [ENTRY_WIDTH-1:0] arr_rdata [WAYS],
  output logic                   arr_wen,
  output logic [SET_WIDTH-1:0]   arr_waddr,
  output logic [WAYS-1:0]        arr_cs,
  output logic [ENTRY_WIDTH-1:0] arr_wdata [WAYS],

  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [WAYS-1:0]        resp_way,
  output logic                   resp_multihit,
  output logic [WAYS-1:0]        resp_victim,
  output logic [SET_WIDTH-1:0]   resp_set,
  output logic [TAG_WIDTH-1:0]   resp_tag
);

  localparam int PTR_W = $clog2(WAYS);

  // Pipeline control
  logic                  advance;
  logic                  req_fire;

  // S1 state and derived data
  logic                  s1_valid;
  logic                  s1_first;
  logic [SET_WIDTH-1:0]  s1_set;
  logic [TAG_WIDTH-1:0]  s1_tag;
  tag_entry_t            s1_hold    [WAYS];
  tag_entry_t            s1_entries [WAYS];
  logic                  s1_upd_match;

  // Compare results
  logic [WAYS-1:0]       cmp_hit_vec;
  logic [WAYS-1:0]       cmp_hit_way;
  logic                  cmp_multihit;
  logic [WAYS-1:0]       cmp_inv_victim;
  logic                  cmp_any_invalid;
  logic                  cmp_hit;

  // S2 state
  logic                  s2_valid;
  logic                  s2_hit;
  logic [WAYS-1:0]       s2_way;
  logic                  s2_multihit;
  logic [WAYS-1:0]       s2_inv_victim;
  logic                  s2_use_rr;
  logic [SET_WIDTH-1:0]  s2_set;
  logic [TAG_WIDTH-1:0]  s2_tag;

  logic [PTR_W-1:0]      rr_ptr;

  // Handshake: S2 can take new data when empty or being drained; S1 can
  // take a new request when empty or moving into S2.
  assign advance   = ~s2_valid | resp_ready;
  assign req_ready = ~s1_valid | advance;
  assign req_fire  = req_valid & req_ready;

  // S0 array read
  assign arr_ren   = req_fire;
  assign arr_raddr = req_set;

  // Array write port is a straight pass-through of the update strobe.
  assign arr_wen   = upd_valid;
  assign arr_waddr = upd_set;
  assign arr_cs    = upd_way;

  // Replicate the update entry to every way; the mask picks the targets.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      arr_wdata[i] = upd_entry;
    end
  end

  assign s1_upd_match = upd_valid & (upd_set == s1_set);

  // Select fresh array data on the first S1 cycle, held data afterwards,
  // and overlay any same-set update onto the targeted ways.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      s1_entries[i] = s1_first ? tag_entry_t'(arr_rdata[i]) : s1_hold[i];
      if (s1_upd_match && upd_way[i]) begin
        s1_entries[i] = tag_entry_t'(upd_entry);
      end
    end
  end

  tag_compare u_tag_compare (
    .entries     (s1_entries),
    .tag         (s1_tag),
    .hit_vec     (cmp_hit_vec),
    .hit_way     (cmp_hit_way),
    .multihit    (cmp_multihit),
    .inv_victim  (cmp_inv_victim),
    .any_invalid (cmp_any_invalid)
  );

  assign cmp_hit = |cmp_hit_vec;

  // S1 occupancy and first-cycle tracking.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
    end else if (req_fire) begin
      s1_valid <= 1'b1;
      s1_first <= 1'b1;
    end else begin
      if (advance) s1_valid <= 1'b0;
      s1_first <= 1'b0;
    end
  end

  // S1 payload and the patched entry snapshot used while stalled.
  // NOTE: these datapath registers carry no reset; they are only consumed
  // while s1_valid/s1_first qualify them, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      s1_set <= req_set;
      s1_tag <= req_tag;
    end
    if (s1_valid) begin
      for (int i = 0; i < WAYS; i++) begin
        s1_hold[i] <= s1_entries[i];
      end
    end
  end

  // S2 response register and round-robin pointer advance on miss handshakes
  // that had to fall back to the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid      <= 1'b0;
      s2_hit        <= 1'b0;
      s2_way        <= '0;
      s2_multihit   <= 1'b0;
      s2_inv_victim <= '0;
      s2_use_rr     <= 1'b0;
      s2_set        <= '0;
      s2_tag        <= '0;
      rr_ptr        <= '0;
    end else begin
      if (s1_valid && advance) begin
        s2_valid      <= 1'b1;
        s2_hit        <= cmp_hit;
        s2_way        <= cmp_hit_way;
        s2_multihit   <= cmp_multihit;
        s2_inv_victim <= (!cmp_hit && cmp_any_invalid) ? cmp_inv_victim : '0;
        s2_use_rr     <= !cmp_hit && !cmp_any_invalid;
        s2_set        <= s1_set;
        s2_tag        <= s1_tag;
      end else if (resp_ready) begin
        s2_valid <= 1'b0;
      end
      if (s2_valid && resp_ready && !s2_hit && s2_use_rr) begin
        rr_ptr <= rr_ptr + PTR_W'(1);
      end
    end
  end

  assign resp_valid    = s2_valid;
  assign resp_hit      = s2_hit;
  assign resp_way      = s2_way;
  assign resp_multihit = s2_multihit;
  assign resp_victim   = s2_use_rr ? (WAYS'(1) << rr_ptr) : s2_inv_victim;
  assign resp_set      = s2_set;
  assign resp_tag      = s2_tag;

endmodule

// File: doc/tag_lookup.md
Name: tag_lookup

Overview:
- Lookup stage directly upstream and downstream of the cache tag array (SyncReadMem instance with WMASK_WIDTH = WAYS).
- Accepts {set, tag} requests, issues the tag-array read, compares the returned per-way entries against the request tag, and selects a victim way.
- Owns the array's write port for tag updates and patches in-flight lookups so they never see stale data.
- Feeds the cache controller / miss handler through a valid/ready response.

Parameters:
- SETS, 2048, number of sets (array depth).
- WAYS, 4, associativity; power of two ≥ 2.
- TAG_WIDTH, 20, tag bits per entry.
- SET_WIDTH, $clog2(SETS), set index width.
- ENTRY_WIDTH, TAG_WIDTH+1, array entry width: {valid, tag}, valid is the MSB.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  lookup request valid.
- req_ready  output  1  lookup request accepted.
- req_set  input  SET_WIDTH  request set index.
- req_tag  input  TAG_WIDTH  request tag.
- upd_valid  input  1  tag update strobe; always accepted, no ready.
- upd_set  input  SET_WIDTH  update set index.
- upd_way  input  WAYS  one-hot way select.
- upd_entry  input  ENTRY_WIDTH  new {valid, tag}.
- arr_ren  output  1  tag array read enable.
- arr_raddr  output  SET_WIDTH  tag array read address.
- arr_rdata  input  ENTRY_WIDTH x WAYS  unpacked per-way data; valid one cycle after arr_ren.
- arr_wen  output  1  tag array write enable.
- arr_waddr  output  SET_WIDTH  tag array write address.
- arr_cs  output  WAYS  per-way write mask.
- arr_wdata  output  ENTRY_WIDTH x WAYS  write data; upd_entry replicated to every way.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumed.
- resp_hit  output  1  any way hit.
- resp_way  output  WAYS  one-hot hit way; lowest index wins on multihit; 0 on miss.
- resp_multihit  output  1  more than one way hit (error indication).
- resp_victim  output  WAYS  one-hot victim way; valid on miss only, 0 on hit.
- resp_set  output  SET_WIDTH  echoed set index.
- resp_tag  output  TAG_WIDTH  echoed tag.

Behaviour:
- Pipeline: S0 (request/array read), S1 (array data return), S2 (registered response). Latency is 2 cycles from request handshake to resp_valid with no backpressure.
- Handshake signals:
  - advance = !s2_valid | resp_ready.
  - req_ready = !s1_valid | advance.
  - S0 is combinational: arr_ren = req_valid & req_ready; arr_raddr = req_set.
- Array write path is combinational pass-through: arr_wen = upd_valid, arr_waddr = upd_set, arr_cs = upd_way, arr_wdata[i] = upd_entry. A same-cycle read/write to the same set relies on the array's write bypass.
- S1 data capture:
  - On the first S1 cycle (s1_first = 1), arr_rdata is used directly and also captured into s1_hold.
  - On any later stalled cycle, s1_hold is used. The array output register is clobbered by writes, so it is never reused.
- S1 patching: if upd_valid & upd_set == s1_set, ways with upd_way[i] = 1 take upd_entry. This applies to both the direct path and s1_hold.
- Compare: hit_i = entry_i.valid & (entry_i.tag == s1_tag). resp_hit = |hit; resp_multihit = popcount(hit) > 1.
- Victim selection:
  - If any entry is invalid, the victim is the lowest-index invalid way.
  - Otherwise the victim is rr_ptr, a log2(WAYS)-bit counter.
  - rr_ptr increments modulo WAYS on each response handshake with resp_hit = 0 and no invalid way present; it wraps WAYS-1 → 0.
- S2 register:
  - Loads when s1_valid & advance; holds all fields stable while resp_valid & !resp_ready.
  - s2_valid clears on handshake unless reloaded that cycle.
- S2 responses are NOT patched by later updates. The consumer must order updates against responses it holds.
- Back-to-back requests sustain 1 lookup per cycle when resp_ready = 1.
- Reset (asynchronous, mid-operation included) discards all in-flight lookups:
  - s1_valid = s2_valid = 0, rr_ptr = 0.
  - resp_valid = 0, resp_hit/resp_multihit = 0, resp_way/resp_victim = 0, resp_set/resp_tag = 0.
  - arr_ren = 0 and arr_wen = 0 while their inputs are low.
  - Array contents are not cleared by this block.

Decomposition:
- Package tag_lookup_pkg holds:
  - typedef tag_entry_t as packed {logic valid; logic [TAG_WIDTH-1:0] tag;};
  - function onehot_lowest(WAYS vector) → one-hot;
  - function popcount_gt1.
- One sub-module, tag_compare: purely combinational, taking WAYS entries plus a tag and producing hit vector, resp_way, multihit, and the invalid-way victim. Pipeline registers and rr_ptr stay in tag_lookup.

Test Plan:
- Hit: set 5 way2 preloaded {1, 0xABCDE}; request set 5 tag 0xABCDE → 2 cycles later resp_hit=1, resp_way=0100, resp_victim=0000, resp_multihit=0.
- Miss and victim:
  - Set 7 with ways 0,1 valid, way2 invalid → resp_hit=0, resp_victim=0100.
  - All ways valid, 5 consecutive misses → victims 0001, 0010, 0100, 1000, 0001 (wrap).
- Patching:
  - Update set 9 way1 {1, 0x12345} in the same cycle as request set 9 tag 0x12345 → hit way 0010.
  - Same update one cycle after the request (lookup in S1) → also hit way 0010.
- Backpressure: resp_ready=0 for 4 cycles with 2 requests issued, plus an update to S1's set during the stall → resp fields stable; req_ready=0 after the second request; the stalled lookup reflects the patch; both responses delivered in order once resp_ready=1.
- Multihit: ways 0 and 3 both hold {1, 0x00011}; request tag 0x00011 → resp_hit=1, resp_way=0001, resp_multihit=1.
- Reset: assert reset low with S1 and S2 both valid → resp_valid=0 immediately (async); after release, rr_ptr=0 and the next lookup completes normally in 2 cycles.
